// File: rtl/cpu24_pkg.sv
// Shared CPU24 datapath constants and the writeback entry record used by
// the execute-to-writeback buffers.
package cpu24_pkg;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 4;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic              zero;
      logic              neg;
   } wb_entry_t;

   function automatic wb_entry_t pack_entry(
      input logic [DATA_W-1:0] data,
      input logic [ADDR_W-1:0] addr,
      input logic              we,
      input logic              zero,
      input logic              neg
   );
      wb_entry_t e;
      e.data = data;
      e.addr = addr;
      e.we   = we;
      e.zero = zero;
      e.neg  = neg;
      return e;
   endfunction

endpackage

// File: rtl/result_flag_gen.sv
// Combinational zero/negative flag generation for a DATA_W result; shared
// by the ALU-family result paths.
module result_flag_gen #(
   parameter int DATA_W = cpu24_pkg::DATA_W
) (
   input  logic [DATA_W-1:0] i_data,
   output logic              o_zero,
   output logic              o_neg
);

   assign o_zero = (i_data == '0);
   assign o_neg  = i_data[DATA_W-1];

endmodule

// File: rtl/shift_result_skid_buffer.sv
// Two-entry skid buffer between the 24-bit shift unit and writeback, carrying
// result flags. Optional forwarding lookup enabled by SHIFT_RESULT_FWD_EN.
module shift_result_skid_buffer #(
   parameter int DATA_W = cpu24_pkg::DATA_W,
   parameter int ADDR_W = cpu24_pkg::ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Data,
   input  logic [ADDR_W-1:0] In_Addr,
   input  logic              In_We,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   output logic [ADDR_W-1:0] Out_Addr,
   output logic              Out_We,
   output logic              Out_Zero,
   output logic              Out_Neg,
`ifdef SHIFT_RESULT_FWD_EN
   input  logic [ADDR_W-1:0] Fwd_Addr,
   output logic              Fwd_Hit,
   output logic [DATA_W-1:0] Fwd_Data,
`endif
   output logic [1:0]        Count
);

   import cpu24_pkg::*;

   // Occupancy doubles as the state encoding.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'(DEPTH);

   wb_entry_t  r_head;
   wb_entry_t  r_skid;
   logic [1:0] r_count;
   logic       r_in_ready;

   logic       w_zero;
   logic       w_neg;
   logic       w_push;
   logic       w_pop;
   wb_entry_t  w_in_entry;
   logic [1:0] w_count_nxt;

   result_flag_gen #(.DATA_W(DATA_W)) u_flags (
      .i_data (In_Data),
      .o_zero (w_zero),
      .o_neg  (w_neg)
   );

   assign w_in_entry = pack_entry(In_Data, In_Addr, In_We, w_zero, w_neg);
   assign w_push     = In_Valid && r_in_ready;
   assign w_pop      = (r_count != ST_EMPTY) && Out_Ready;

   always_comb begin
      w_count_nxt = r_count;
      case (r_count)
         ST_EMPTY: if (w_push) w_count_nxt = ST_ONE;
         ST_ONE: begin
            if (w_push && !w_pop)      w_count_nxt = ST_FULL;
            else if (!w_push && w_pop) w_count_nxt = ST_EMPTY;
         end
         ST_FULL:  if (w_pop) w_count_nxt = ST_ONE;
         default:  w_count_nxt = ST_EMPTY;
      endcase
   end

   // Ready is registered from next occupancy so it stays low through reset
   // and rises on the first edge after release.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_head     <= '0;
         r_skid     <= '0;
         r_count    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         case (r_count)
            ST_EMPTY: if (w_push) r_head <= w_in_entry;
            ST_ONE: begin
               if (w_push && w_pop) r_head <= w_in_entry;
               else if (w_push)     r_skid <= w_in_entry;
            end
            ST_FULL:  if (w_pop) r_head <= r_skid;
            default:  r_head <= r_head;
         endcase
         r_count    <= w_count_nxt;
         r_in_ready <= (w_count_nxt != ST_FULL);
      end
   end

   assign In_Ready  = r_in_ready;
   assign Count     = r_count;
   assign Out_Valid = (r_count != ST_EMPTY);
   assign Out_Data  = r_head.data;
   assign Out_Addr  = r_head.addr;
   assign Out_We    = r_head.we;
   assign Out_Zero  = r_head.zero;
   assign Out_Neg   = r_head.neg;

`ifdef SHIFT_RESULT_FWD_EN
   logic w_head_hit;
   logic w_skid_hit;

   // Skid holds the younger entry, so it wins; register 0 never forwards.
   assign w_head_hit = (r_count != ST_EMPTY) && r_head.we &&
                       (r_head.addr == Fwd_Addr) && (Fwd_Addr != '0);
   assign w_skid_hit = (r_count == ST_FULL) && r_skid.we &&
                       (r_skid.addr == Fwd_Addr) && (Fwd_Addr != '0);
   assign Fwd_Hit    = w_head_hit || w_skid_hit;
   assign Fwd_Data   = w_skid_hit ? r_skid.data :
                       w_head_hit ? r_head.data : '0;
`endif

endmodule

// File: tb/tb_shift_result_skid_buffer.sv
// Randomized self-checking bench for shift_result_skid_buffer against a
// queue-based reference model. Define SHIFT_RESULT_FWD_EN to cover forwarding.
module tb_shift_result_skid_buffer;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        In_Valid;
   logic        In_Ready;
   logic [23:0] In_Data;
   logic [3:0]  In_Addr;
   logic        In_We;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [23:0] Out_Data;
   logic [3:0]  Out_Addr;
   logic        Out_We;
   logic        Out_Zero;
   logic        Out_Neg;
   logic [1:0]  Count;
`ifdef SHIFT_RESULT_FWD_EN
   logic [3:0]  Fwd_Addr;
   logic        Fwd_Hit;
   logic [23:0] Fwd_Data;
`endif

   shift_result_skid_buffer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .In_Data   (In_Data),
      .In_Addr   (In_Addr),
      .In_We     (In_We),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Out_Data  (Out_Data),
      .Out_Addr  (Out_Addr),
      .Out_We    (Out_We),
      .Out_Zero  (Out_Zero),
      .Out_Neg   (Out_Neg),
`ifdef SHIFT_RESULT_FWD_EN
      .Fwd_Addr  (Fwd_Addr),
      .Fwd_Hit   (Fwd_Hit),
      .Fwd_Data  (Fwd_Data),
`endif
      .Count     (Count)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [23:0] d;
      logic [3:0]  a;
      logic        we;
   } ent_t;

   ent_t q[$];
   bit   exp_ready;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check_eq("count", 32'(Count), 32'(q.size()));
      check_eq("out_valid", 32'(Out_Valid), 32'(q.size() > 0));
      check_eq("in_ready", 32'(In_Ready), 32'(exp_ready));
      if (q.size() > 0) begin
         check_eq("out_data", 32'(Out_Data), 32'(q[0].d));
         check_eq("out_addr", 32'(Out_Addr), 32'(q[0].a));
         check_eq("out_we", 32'(Out_We), 32'(q[0].we));
         check_eq("out_zero", 32'(Out_Zero), 32'(q[0].d == 24'd0));
         check_eq("out_neg", 32'(Out_Neg), 32'(q[0].d >= 24'h800000));
      end
`ifdef SHIFT_RESULT_FWD_EN
      begin
         bit          hit = 1'b0;
         logic [23:0] fd  = '0;
         for (int i = 0; i < q.size(); i++)
            if (q[i].we && q[i].a == Fwd_Addr && Fwd_Addr != 4'd0) begin
               hit = 1'b1;
               fd  = q[i].d;
            end
         check_eq("fwd_hit", 32'(Fwd_Hit), 32'(hit));
         if (hit) check_eq("fwd_data", 32'(Fwd_Data), 32'(fd));
      end
`endif
   endtask

   // One clock: update the model from the values present at the edge, then
   // compare on the falling edge.
   task automatic cycle();
      bit acc;
      bit pop;
      @(posedge Clock);
      if (Reset) begin
         q.delete();
         exp_ready = 1'b0;
      end else begin
         acc = In_Valid && exp_ready;
         pop = (q.size() > 0) && Out_Ready;
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{In_Data, In_Addr, In_We});
         exp_ready = (q.size() < 2);
      end
      @(negedge Clock);
      check_outputs();
   endtask

   task automatic drive(input bit v, input logic [23:0] d, input logic [3:0] a, input bit we);
      In_Valid = v;
      In_Data  = d;
      In_Addr  = a;
      In_We    = we;
   endtask

   task automatic drain();
      In_Valid  = 1'b0;
      Out_Ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
   endtask

   initial begin
      Reset     = 1'b1;
      Out_Ready = 1'b0;
      drive(1'b0, 24'd0, 4'd0, 1'b0);
`ifdef SHIFT_RESULT_FWD_EN
      Fwd_Addr = 4'd0;
`endif
      exp_ready = 1'b0;
      #1;
      check_eq("rst_in_ready", 32'(In_Ready), 32'd0);
      check_eq("rst_out_valid", 32'(Out_Valid), 32'd0);
      check_eq("rst_count", 32'(Count), 32'd0);
      check_eq("rst_out_data", 32'(Out_Data), 32'd0);
      cycle();
      cycle();
      Reset = 1'b0;
      cycle();
      check_eq("ready_after_rst", 32'(In_Ready), 32'd1);

      // Single push with writeback ready.
      Out_Ready = 1'b1;
      drive(1'b1, 24'h000800, 4'd5, 1'b1);
      cycle();
      check_eq("t1_valid", 32'(Out_Valid), 32'd1);
      check_eq("t1_data", 32'(Out_Data), 32'h000800);
      check_eq("t1_zero", 32'(Out_Zero), 32'd0);
      check_eq("t1_neg", 32'(Out_Neg), 32'd0);
      In_Valid = 1'b0;
      cycle();
      check_eq("t1_count0", 32'(Count), 32'd0);

      // Fill under backpressure, third push held.
      Out_Ready = 1'b0;
      drive(1'b1, 24'h800000, 4'd1, 1'b1);
      cycle();
      drive(1'b1, 24'h000000, 4'd2, 1'b0);
      cycle();
      check_eq("full_count", 32'(Count), 32'd2);
      check_eq("full_ready", 32'(In_Ready), 32'd0);
      drive(1'b1, 24'h123456, 4'd3, 1'b1);
      cycle();
      cycle();
      check_eq("held_head", 32'(Out_Data), 32'h800000);
      check_eq("held_neg", 32'(Out_Neg), 32'd1);
      Out_Ready = 1'b1;
      cycle();
      check_eq("pop2_data", 32'(Out_Data), 32'h000000);
      check_eq("pop2_zero", 32'(Out_Zero), 32'd1);
      drain();

      // Simultaneous push and pop at Count = 1.
      Out_Ready = 1'b0;
      drive(1'b1, 24'h00AAAA, 4'd4, 1'b1);
      cycle();
      Out_Ready = 1'b1;
      drive(1'b1, 24'h00BBBB, 4'd6, 1'b1);
      cycle();
      check_eq("pp_count", 32'(Count), 32'd1);
      check_eq("pp_head", 32'(Out_Data), 32'h00BBBB);
      drain();

      // Continuous stream.
      for (int i = 0; i < 100; i++) begin
         Out_Ready = 1'b1;
         drive(1'b1, 24'($urandom), 4'($urandom), 1'($urandom));
         cycle();
         check_eq("stream_le1", 32'(Count <= 2'd1), 32'd1);
      end
      drain();

      // Random traffic; producer holds data while stalled.
      for (int i = 0; i < 400; i++) begin
         if (!(In_Valid && !exp_ready))
            drive(1'($urandom), ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom));
         Out_Ready = 1'($urandom);
`ifdef SHIFT_RESULT_FWD_EN
         Fwd_Addr = 4'($urandom_range(0, 3));
`endif
         cycle();
      end
      drain();

`ifdef SHIFT_RESULT_FWD_EN
      Out_Ready = 1'b0;
      drive(1'b1, 24'h000011, 4'd3, 1'b1);
      cycle();
      drive(1'b1, 24'h000022, 4'd3, 1'b1);
      cycle();
      In_Valid = 1'b0;
      Fwd_Addr = 4'd3;
      #1;
      check_eq("fwd3_hit", 32'(Fwd_Hit), 32'd1);
      check_eq("fwd3_data", 32'(Fwd_Data), 32'h000022);
      Fwd_Addr = 4'd0;
      #1;
      check_eq("fwd0_hit", 32'(Fwd_Hit), 32'd0);
      drain();
`endif

      // Asynchronous reset between edges while full.
      Out_Ready = 1'b0;
      drive(1'b1, 24'h0F0F0F, 4'd7, 1'b1);
      cycle();
      drive(1'b1, 24'h00F0F0, 4'd8, 1'b1);
      cycle();
      check_eq("pre_rst_count", 32'(Count), 32'd2);
      In_Valid = 1'b0;
      #2;
      Reset = 1'b1;
      q.delete();
      exp_ready = 1'b0;
      #1;
      check_eq("arst_valid", 32'(Out_Valid), 32'd0);
      check_eq("arst_count", 32'(Count), 32'd0);
      check_eq("arst_ready", 32'(In_Ready), 32'd0);
      @(negedge Clock);
      Reset = 1'b0;
      #1;
      check_eq("arst_ready_hold", 32'(In_Ready), 32'd0);
      cycle();
      check_eq("arst_ready_up", 32'(In_Ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
